// File: rtl/wb_reg_guard_pkg.sv
// Shared definitions for the registered Wishbone guard bridge: FSM states,
// slave response codes and small elaboration-time helpers.
package wb_reg_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2,
    RSP_RTY  = 2'd3
  } rsp_t;

  // Counter width able to hold 0..maxval; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned maxval);
    return (maxval == 0) ? 1 : $clog2(maxval + 1);
  endfunction

  // Simultaneous slave terminations resolve as err > ack > rty.
  function automatic rsp_t decode_rsp(input logic ack, input logic err, input logic rty);
    if (err)      return RSP_ERR;
    else if (ack) return RSP_ACK;
    else if (rty) return RSP_RTY;
    else          return RSP_NONE;
  endfunction

endpackage

// File: rtl/wb_txn_timer.sv
// Watchdog counter for one outstanding slave strobe: cleared between strobes,
// counts while enabled, saturates, and flags expiry at TIMEOUT_CYCLES-1.
module wb_txn_timer
  import wb_reg_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = cnt_width(TIMEOUT_CYCLES);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_timer;
      assign unused_timer = ^{clk, rst, clr, en};
      assign expire       = 1'b0;
    end else begin : g_on
      localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
      localparam logic [W-1:0] SAT  = W'(TIMEOUT_CYCLES);
      logic [W-1:0] count;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          count <= '0;
        end else if (en && (count != SAT)) begin
          count <= count + 1'b1;
        end
      end

      assign expire = en && (count == LAST);
    end
  endgenerate

endmodule

// File: rtl/wb_reg_guard.sv
// Registered Wishbone classic bridge with a bus-timeout watchdog and bounded
// automatic replay of RTY-terminated cycles.
module wb_reg_guard
  import wb_reg_guard_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  input  logic                    wbm_cyc_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,
  output logic                    wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
  output logic                    wbs_we_o,
  output logic [SELECT_WIDTH-1:0] wbs_sel_o,
  output logic                    wbs_stb_o,
  output logic                    wbs_cyc_o,
  input  logic                    wbs_ack_i,
  input  logic                    wbs_err_i,
  input  logic                    wbs_rty_i,
  output logic                    timeout_o,
  output logic                    busy_o
);

  localparam int unsigned RW = cnt_width(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_t                  state, state_n;
  logic [RW-1:0]           retry_cnt, retry_cnt_n;
  logic [ADDR_WIDTH-1:0]   adr_n;
  logic [DATA_WIDTH-1:0]   wdat_n, rdat_n;
  logic [SELECT_WIDTH-1:0] sel_n;
  logic                    we_n, stb_n, cyc_n;
  logic                    ack_n, err_n, rty_n, tmo_n;
  logic                    expire;
  rsp_t                    rsp;

  wb_txn_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (state != ST_REQ),
    .en    (state == ST_REQ),
    .expire(expire)
  );

  assign rsp    = decode_rsp(wbs_ack_i, wbs_err_i, wbs_rty_i);
  assign busy_o = (state != ST_IDLE);

  always_comb begin
    state_n     = state;
    retry_cnt_n = retry_cnt;
    adr_n       = wbs_adr_o;
    wdat_n      = wbs_dat_o;
    we_n        = wbs_we_o;
    sel_n       = wbs_sel_o;
    stb_n       = wbs_stb_o;
    cyc_n       = wbs_cyc_o;
    rdat_n      = wbm_dat_o;
    ack_n       = 1'b0;
    err_n       = 1'b0;
    rty_n       = 1'b0;
    tmo_n       = 1'b0;

    case (state)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          adr_n       = wbm_adr_i;
          wdat_n      = wbm_dat_i;
          we_n        = wbm_we_i;
          sel_n       = wbm_sel_i;
          stb_n       = 1'b1;
          cyc_n       = 1'b1;
          retry_cnt_n = '0;
          state_n     = ST_REQ;
        end
      end
      ST_REQ: begin
        // A master that has walked away gets no response, even if the slave answers now.
        if (!wbm_cyc_i) begin
          stb_n   = 1'b0;
          cyc_n   = 1'b0;
          state_n = ST_IDLE;
        end else begin
          case (rsp)
            RSP_ERR: begin
              rdat_n  = '0;
              err_n   = 1'b1;
              stb_n   = 1'b0;
              cyc_n   = 1'b0;
              state_n = ST_RESP;
            end
            RSP_ACK: begin
              rdat_n  = wbs_dat_i;
              ack_n   = 1'b1;
              stb_n   = 1'b0;
              cyc_n   = 1'b0;
              state_n = ST_RESP;
            end
            RSP_RTY: begin
              if (retry_cnt < RETRY_MAX) begin
                retry_cnt_n = retry_cnt + 1'b1;
                stb_n       = 1'b0;
                state_n     = ST_GAP;
              end else begin
                rty_n   = 1'b1;
                stb_n   = 1'b0;
                cyc_n   = 1'b0;
                state_n = ST_RESP;
              end
            end
            default: begin
              if (expire) begin
                rdat_n  = '0;
                err_n   = 1'b1;
                tmo_n   = 1'b1;
                stb_n   = 1'b0;
                cyc_n   = 1'b0;
                state_n = ST_RESP;
              end
            end
          endcase
        end
      end
      ST_GAP: begin
        if (!wbm_cyc_i) begin
          stb_n   = 1'b0;
          cyc_n   = 1'b0;
          state_n = ST_IDLE;
        end else begin
          stb_n   = 1'b1;
          state_n = ST_REQ;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      retry_cnt <= '0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_sel_o <= '0;
      wbs_stb_o <= 1'b0;
      wbs_cyc_o <= 1'b0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      wbm_rty_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      state     <= state_n;
      retry_cnt <= retry_cnt_n;
      wbs_adr_o <= adr_n;
      wbs_dat_o <= wdat_n;
      wbs_we_o  <= we_n;
      wbs_sel_o <= sel_n;
      wbs_stb_o <= stb_n;
      wbs_cyc_o <= cyc_n;
      wbm_dat_o <= rdat_n;
      wbm_ack_o <= ack_n;
      wbm_err_o <= err_n;
      wbm_rty_o <= rty_n;
      timeout_o <= tmo_n;
    end
  end

endmodule

// File: tb/tb_wb_reg_guard.sv
// Directed-vector bench for wb_reg_guard with TIMEOUT_CYCLES=8 and MAX_RETRY=3.
module tb_wb_reg_guard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wbm_adr_i, wbm_dat_i, wbm_dat_o;
  logic        wbm_we_i;
  logic [3:0]  wbm_sel_i;
  logic        wbm_stb_i, wbm_cyc_i;
  logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i;
  logic        wbs_we_o;
  logic [3:0]  wbs_sel_o;
  logic        wbs_stb_o, wbs_cyc_o;
  logic        wbs_ack_i, wbs_err_i, wbs_rty_i;
  logic        timeout_o, busy_o;

  int errors = 0;
  int checks = 0;

  wb_reg_guard #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
    .TIMEOUT_CYCLES(8), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
    .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cyc_i(wbm_cyc_i), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o), .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o),
    .wbs_dat_i(wbs_dat_i), .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o),
    .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o), .wbs_ack_i(wbs_ack_i),
    .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i), .timeout_o(timeout_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_req(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                       input logic [3:0] sel);
    wbm_adr_i = adr; wbm_dat_i = dat; wbm_we_i = we; wbm_sel_i = sel;
    wbm_cyc_i = 1'b1; wbm_stb_i = 1'b1;
  endtask

  task automatic m_idle();
    wbm_cyc_i = 1'b0; wbm_stb_i = 1'b0; wbm_we_i = 1'b0;
    wbm_adr_i = '0; wbm_dat_i = '0; wbm_sel_i = '0;
  endtask

  task automatic s_idle();
    wbs_ack_i = 1'b0; wbs_err_i = 1'b0; wbs_rty_i = 1'b0; wbs_dat_i = '0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_resp"}, {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 4'b0000);
    check({tag, "_bus"}, {wbs_stb_o, wbs_cyc_o, busy_o}, 3'b000);
  endtask

  // Runs one request with a slave that answers rty n_rty times then acks
  // (or stays silent), and tallies what the bridge did cycle by cycle.
  task automatic run_txn(input int n_rty, input bit silent,
                         output int nstb, output int nstb_cyc, output int ngap,
                         output int nack, output int nerr, output int nrty,
                         output int term_cyc, output bit term_tmo);
    int sent = 0;
    bit prev_stb = 1'b0;
    nstb = 0; nstb_cyc = 0; ngap = 0; nack = 0; nerr = 0; nrty = 0;
    term_cyc = 0; term_tmo = 1'b0;
    m_req(32'h200, 32'h0, 1'b0, 4'hF);
    tick();
    for (int c = 1; c <= 40; c++) begin
      if (wbs_stb_o && !prev_stb) nstb++;
      if (wbs_stb_o) nstb_cyc++;
      if (wbs_cyc_o && !wbs_stb_o) ngap++;
      prev_stb = wbs_stb_o;
      if (wbm_ack_o) nack++;
      if (wbm_err_o) nerr++;
      if (wbm_rty_o) nrty++;
      if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
        term_cyc = c;
        term_tmo = timeout_o;
        m_idle();
        s_idle();
        tick();
        break;
      end
      s_idle();
      if (wbs_stb_o && !silent) begin
        if (sent < n_rty) begin
          wbs_rty_i = 1'b1;
          sent++;
        end else begin
          wbs_ack_i = 1'b1;
          wbs_dat_i = 32'hA5A5_0001;
        end
      end
      tick();
    end
    check("txn_terminated", 32'(term_cyc != 0), 32'd1);
  endtask

  int nstb, nstb_cyc, ngap, nack, nerr, nrty, term_cyc;
  bit term_tmo;

  initial begin
    rst = 1'b1;
    m_idle();
    s_idle();
    repeat (3) tick();
    check("reset_mdat", wbm_dat_o, 32'h0);
    check("reset_sadr", {wbs_adr_o, wbs_dat_o}, 64'h0);
    check("reset_ctl", {wbs_we_o, wbs_sel_o}, 5'h0);
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Write with a zero-wait slave: ack visible to master two cycles after the request.
    m_req(32'h100, 32'hDEAD_BEEF, 1'b1, 4'hF);
    tick();
    check("t1_adr", wbs_adr_o, 32'h100);
    check("t1_dat", wbs_dat_o, 32'hDEAD_BEEF);
    check("t1_we_sel", {wbs_we_o, wbs_sel_o}, 5'h1F);
    check("t1_c1_bus", {wbs_stb_o, wbs_cyc_o, busy_o, wbm_ack_o}, 4'b1110);
    wbs_ack_i = 1'b1;
    tick();
    check("t1_c2_ack", {wbm_ack_o, wbm_err_o, wbm_rty_o}, 3'b100);
    check("t1_c2_bus", {wbs_stb_o, wbs_cyc_o, busy_o}, 3'b001);
    s_idle();
    tick();
    check("t1_c3_ack_low", wbm_ack_o, 1'b0);
    check("t1_c3_idle", {wbs_stb_o, busy_o}, 2'b00);
    m_idle();
    tick();
    check("t1_no_reissue", {wbs_stb_o, wbs_cyc_o}, 2'b00);

    // Read with five wait states.
    m_req(32'h40, 32'h0, 1'b0, 4'hF);
    tick();
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("t2_wait%0d_stb", i), {wbs_stb_o, wbm_ack_o}, 2'b10);
      tick();
    end
    check("t2_c6_stb", wbs_stb_o, 1'b1);
    check("t2_adr_we", {wbs_adr_o, wbs_we_o}, {32'h40, 1'b0});
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'h1234_5678;
    tick();
    check("t2_ack", wbm_ack_o, 1'b1);
    check("t2_rdat", wbm_dat_o, 32'h1234_5678);
    s_idle();
    m_idle();
    tick();
    check("t2_done", {wbm_ack_o, busy_o}, 2'b00);

    // Two retries then ack.
    run_txn(2, 1'b0, nstb, nstb_cyc, ngap, nack, nerr, nrty, term_cyc, term_tmo);
    check("t3_strobes", nstb, 3);
    check("t3_gaps", ngap, 2);
    check("t3_acks", nack, 1);
    check("t3_rtys", nrty + nerr, 0);
    check("t3_term_cyc", term_cyc, 6);
    check("t3_rdat", wbm_dat_o, 32'hA5A5_0001);

    // Slave always retries: initial strobe plus three replays, then rty to master.
    run_txn(100, 1'b0, nstb, nstb_cyc, ngap, nack, nerr, nrty, term_cyc, term_tmo);
    check("t4_strobes", nstb, 4);
    check("t4_gaps", ngap, 3);
    check("t4_rty", nrty, 1);
    check("t4_no_ack_err", nack + nerr, 0);
    check("t4_term_cyc", term_cyc, 8);
    check("t4_after", {wbm_rty_o, busy_o}, 2'b00);

    // Silent slave trips the watchdog after eight strobe cycles.
    run_txn(0, 1'b1, nstb, nstb_cyc, ngap, nack, nerr, nrty, term_cyc, term_tmo);
    check("t5_stb_cycles", nstb_cyc, 8);
    check("t5_err", nerr, 1);
    check("t5_err_with_tmo", term_tmo, 1'b1);
    check("t5_term_cyc", term_cyc, 9);
    check("t5_dat_zero", wbm_dat_o, 32'h0);
    check("t5_after", {timeout_o, wbm_err_o}, 2'b00);

    // Ack in the watchdog's final cycle beats the timeout.
    m_req(32'h300, 32'h0, 1'b0, 4'h3);
    tick();
    repeat (7) tick();
    check("t5b_c8_stb", wbs_stb_o, 1'b1);
    wbs_ack_i = 1'b1;
    wbs_dat_i = 32'hCAFE_0008;
    tick();
    check("t5b_ack_wins", {wbm_ack_o, wbm_err_o, timeout_o}, 3'b100);
    check("t5b_rdat", wbm_dat_o, 32'hCAFE_0008);
    s_idle(); m_idle();
    tick();

    // Err and ack together: err wins and data is zeroed.
    m_req(32'h310, 32'h0, 1'b0, 4'hF);
    tick();
    wbs_ack_i = 1'b1; wbs_err_i = 1'b1; wbs_rty_i = 1'b1; wbs_dat_i = 32'h5555_5555;
    tick();
    check("t_prio_err", {wbm_ack_o, wbm_err_o, wbm_rty_o, timeout_o}, 4'b0100);
    check("t_prio_dat", wbm_dat_o, 32'h0);
    s_idle(); m_idle();
    tick();

    // Master abort in cycle 3 of a stalled request.
    m_req(32'h400, 32'h1, 1'b1, 4'hF);
    tick();
    tick();
    tick();
    check("t6_c3_stalled", {wbs_stb_o, wbs_cyc_o}, 2'b11);
    m_idle();
    tick();
    check_quiet("t6_abort");
    tick();
    check_quiet("t6_abort_next");

    // Reset while a request is outstanding, with the slave acking at the same time.
    m_req(32'h500, 32'h2, 1'b1, 4'hF);
    tick();
    check("t6r_req", wbs_stb_o, 1'b1);
    rst = 1'b1;
    wbs_ack_i = 1'b1;
    tick();
    check_quiet("t6r_reset");
    check("t6r_regs", {wbs_adr_o, wbs_dat_o}, 64'h0);
    rst = 1'b0;
    s_idle(); m_idle();
    tick();
    check_quiet("t6r_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
